// File: rtl/ibex_instr_resp_pkg.sv
// Shared types and widths for the Ibex instruction-fetch responder.
package ibex_instr_resp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } resp_state_e;

  localparam int unsigned WAIT_CNT_W = 4;

  // Counter preload for a fresh request; the load cycle itself counts as one wait state.
  function automatic logic [WAIT_CNT_W-1:0] wait_cnt_load(input int unsigned wait_states);
    return (wait_states == 0) ? '0 : WAIT_CNT_W'(wait_states - 1);
  endfunction

endpackage

// File: rtl/ibex_instr_mem_responder.sv
// Ibex instruction-fetch responder: wait-state insertion before grant, range check,
// and a one-cycle response stage in front of a synchronous instruction SRAM.
module ibex_instr_mem_responder
  import ibex_instr_resp_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned MEM_WORDS   = 16384,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         instr_req_i,
  input  logic [31:0]                  instr_addr_i,
  output logic                         instr_gnt_o,
  output logic                         instr_rvalid_o,
  output logic [31:0]                  instr_rdata_o,
  output logic                         instr_err_o,
  output logic                         mem_req_o,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
  input  logic [31:0]                  mem_rdata_i,
  output logic                         busy_o
);

  localparam int unsigned           AW       = $clog2(MEM_WORDS);
  localparam logic [32:0]           BASE_EXT = {1'b0, ADDR_BASE};
  localparam logic [32:0]           SPAN_EXT = 33'(MEM_WORDS) << 2;
  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = wait_cnt_load(WAIT_STATES);

  resp_state_e           state_q;
  logic [WAIT_CNT_W-1:0] cnt_q;
  logic                  rvalid_q;
  logic                  err_q;

  logic [32:0] offset_ext;
  logic        in_range;
  logic        gnt;

  // Below-base addresses wrap to a huge 33-bit offset, so one compare covers both bounds.
  assign offset_ext = {1'b0, instr_addr_i} - BASE_EXT;
  assign in_range   = offset_ext < SPAN_EXT;

  always_comb begin
    gnt = 1'b0;
    if (WAIT_STATES == 0) begin
      gnt = instr_req_i;
    end else if (state_q == WAIT && cnt_q == '0) begin
      gnt = instr_req_i;
    end
    if (rst_i) begin
      gnt = 1'b0;
    end
  end

  assign instr_gnt_o = gnt;
  assign mem_req_o   = gnt & in_range;
  assign mem_addr_o  = offset_ext[AW+1:2];

  // Wait-state FSM plus response stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= gnt;
      err_q    <= gnt & ~in_range;
      if (WAIT_STATES != 0) begin
        unique case (state_q)
          IDLE: begin
            if (instr_req_i) begin
              state_q <= WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end
          WAIT: begin
            if (!instr_req_i) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  // Data is only meaningful alongside rvalid; held at zero otherwise so reset reads clean.
  assign instr_rvalid_o = rvalid_q;
  assign instr_err_o    = err_q;
  assign instr_rdata_o  = (rvalid_q && !err_q) ? mem_rdata_i : 32'h0;
  assign busy_o         = (state_q == WAIT) | rvalid_q;

endmodule
